// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: chain of DEPTH skid-buffered valid/ready stages with synchronous flush
//   clk        : clock, every state update on its rising edge
//   reset      : synchronous active-high reset, beats flush
//   flush      : synchronous discard of every held entry (bubbles inserted)
//   in_valid   : upstream offers in_data
//   in_ready   : chain accepts this cycle (low during reset and flush)
//   in_data    : upstream payload, WIDTH bits
//   out_valid  : out_data holds the head entry
//   out_ready  : downstream consumes this cycle
//   out_data   : head payload straight from the last stage's main register
//   count      : number of entries held across the whole chain
module elastic_pipe_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(2*DEPTH+1)-1:0] count
);
    localparam int unsigned   CW      = $clog2(2*DEPTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(2*DEPTH);

    typedef enum logic [1:0] {EMPTY, HALF, FULL} stage_state_t;

    logic             st_valid [DEPTH];
    logic             st_ready [DEPTH];
    logic [WIDTH-1:0] st_data  [DEPTH];
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = st_ready[0] && !flush && !reset;
    assign out_valid = st_valid[DEPTH-1];
    assign out_data  = st_data[DEPTH-1];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        stage_state_t     state;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic [WIDTH-1:0] up_data;
        logic             rdy_q;
        logic             take;
        logic             give;
        if (s == 0) begin : g_head
            assign take    = in_fire;
            assign up_data = in_data;
        end else begin : g_link
            assign take    = st_valid[s-1] && rdy_q;
            assign up_data = st_data[s-1];
        end
        if (s == DEPTH-1) begin : g_tail
            assign give = (state != EMPTY) && out_ready;
        end else begin : g_mid
            assign give = (state != EMPTY) && st_ready[s+1];
        end
        assign st_valid[s] = state != EMPTY;
        assign st_ready[s] = rdy_q;
        assign st_data[s]  = main_q;
        // rdy_q tracks (next state != FULL) so the upstream ready is a flop, not a
        // combinational function of the downstream ready
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                state  <= EMPTY;
                main_q <= RESET_VAL;
                skid_q <= RESET_VAL;
                rdy_q  <= 1'b1;
            end else begin
                case (state)
                    EMPTY: if (take) begin
                        state  <= HALF;
                        main_q <= up_data;
                    end
                    HALF: if (take && !give) begin
                        state  <= FULL;
                        skid_q <= up_data;
                        rdy_q  <= 1'b0;
                    end else if (take) begin
                        main_q <= up_data;
                    end else if (give) begin
                        state <= EMPTY;
                    end
                    FULL: if (give) begin
                        state  <= HALF;
                        main_q <= skid_q;
                        rdy_q  <= 1'b1;
                    end
                    default: begin
                        state <= EMPTY;
                        rdy_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            count <= '0;
        else if (in_fire && !out_fire && count != CNT_MAX)
            count <= count + CW'(1);
        else if (out_fire && !in_fire && count != '0)
            count <= count - CW'(1);
    end

    a_params: assert property (@(posedge clk) WIDTH >= 1 && DEPTH >= 1);
    a_count_max: assert property (@(posedge clk) reset || count <= CNT_MAX);
    a_out_stable: assert property (@(posedge clk)
        (out_valid && !out_ready && !reset && !flush) |=> $stable(out_data));
endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the enable-gated register banks. It is a chain of DEPTH elastic pipeline stages carrying a WIDTH-bit payload under a valid/ready handshake.
- Each stage has a skid entry, so every ready signal is registered and no combinational ready path crosses the chain. A synchronous flush inserts bubbles.
- Used between CPU pipeline stages (e.g. IF/ID, ID/EX) where stall and flush must replace per-bank enable wiring.

Parameters:
- WIDTH, 64, payload width in bits; must be >= 1.
- DEPTH, 1, number of chained elastic stages; must be >= 1.
- RESET_VAL, 0 (WIDTH bits), data value loaded into every entry on reset or flush.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  chain can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  WIDTH  head payload.
- count  output  $clog2(2*DEPTH+1)  total entries held in the chain.

Behaviour:
- Transfers: input transfer = in_valid & in_ready at posedge; output transfer = out_valid & out_ready at posedge. The same handshake applies between internal stages.
- Stage storage: each stage holds a main register and a skid register, each with a valid bit.
- Stage states:
  - EMPTY: no entries.
  - HALF: main entry only.
  - FULL: main and skid entries.
- A stage's upstream ready is registered and equals (state != FULL).
- Stage transitions, per cycle (in = upstream transfer, out = downstream transfer):
  - EMPTY + in -> HALF.
  - HALF + in + !out -> FULL; the new data goes to skid.
  - HALF + !in + out -> EMPTY.
  - HALF + in + out -> HALF; main takes the new data.
  - FULL + out -> HALF; skid moves to main.
  - FULL cannot accept in, because its ready is low.
- Ordering: strict FIFO order; no entry is dropped or duplicated except by flush.
- Outputs: out_valid and out_data come directly from the last stage's main register (registered outputs). in_ready = first stage's registered ready AND !flush.
- Latency: with every stage empty and out_ready held high, data accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1 (visible in the cycle following edge N+DEPTH-1). For DEPTH=1: visible the cycle after acceptance.
- Throughput: one transfer per cycle sustained when out_ready is held high.
- Capacity: 2*DEPTH entries. With out_ready low the chain fills completely, then in_ready falls.
- count: incremented on an input transfer, decremented on an output transfer, unchanged when both or neither occur. It saturates logically, never exceeding 2*DEPTH or going below 0.
- Reset (highest priority), on the posedge with reset=1:
  - all valid bits = 0, all data = RESET_VAL, count = 0, out_valid = 0, out_data = RESET_VAL.
  - internal ready registers = 1, but in_ready = 0 during any cycle reset is high.
  - first acceptance is possible in the cycle after reset deasserts.
- Flush (priority below reset):
  - at the posedge with flush=1: all valid bits = 0, data = RESET_VAL, count = 0, ready registers = 1.
  - in_ready is forced 0 in the flush cycle, so no input is taken.
  - an output transfer occurring in the flush cycle (out_valid & out_ready) is a completed consumption; downstream owns that entry.
- Simultaneous reset and flush: behaves as reset.
- Mid-operation reset or flush: takes effect on that edge regardless of handshake state; no partial entries survive.
- Data regs: loaded only on a transfer into that register; they hold otherwise (enable-gated, no toggling).
- Assertions:
  - initial: WIDTH >= 1, DEPTH >= 1.
  - runtime: count <= 2*DEPTH.
  - runtime: out_data stable while out_valid & !out_ready.

Test Plan:
- Reset (WIDTH=64, DEPTH=2): reset high 2 cycles -> out_valid=0, count=0, out_data=0, in_ready=0 during reset and 1 the cycle after.
- Pass-through (DEPTH=2, out_ready=1): send 0x11, 0x22, 0x33 on consecutive cycles -> they appear on out_data in order on consecutive cycles; first appears after 2 edges; count peaks at 2.
- Backpressure fill (DEPTH=2, out_ready=0): push 0xA0..0xA5 -> 4 accepted, in_ready=0 after the 4th, count=4. Then raise out_ready -> 0xA0..0xA3 drain in order; in_ready returns 1.
- Simultaneous in/out (DEPTH=1, HALF holding 0x5): in 0x6 with out_ready=1 -> 0x5 consumed, 0x6 in main, count stays 1.
- Flush mid-stream (DEPTH=3, count=5): assert flush 1 cycle with in_valid=1, out_ready=1 -> in_ready=0 that cycle; the head entry is consumed; the next cycle shows count=0, out_valid=0, out_data=RESET_VAL.
- Reset+flush together mid-fill: both high -> identical state to the reset scenario; the offered input is not accepted.
